// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and the PWM compare helper for the 16-channel PWM peripheral.
package pwm_peripheral_pkg;

    localparam int PWM_BITS         = 8;
    localparam int PRESCALE_DEFAULT = 13;
    localparam int EN_WIDTH         = 16;

    localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;

    // Full-scale duty is forced high so the last counter step never drops low.
    function automatic logic pwm_level(input logic [PWM_BITS-1:0] cnt,
                                       input logic [PWM_BITS-1:0] duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM counter; flags the tick on which the counter wraps 0xFF->0x00.
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] cnt,
    output logic                wrap
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRESC_MAX);
    assign wrap = tick && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            cnt   <= '0;
        end else begin
            if (tick) begin
                presc <= '0;
                cnt   <= cnt + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// 16 outputs, each off, static-on or PWM; duty is shadowed at the period wrap, enables are not.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int PRESCALE = PRESCALE_DEFAULT,
    parameter int PWM_BITS = pwm_peripheral_pkg::PWM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [PWM_BITS-1:0] pwm_duty_cycle,
    output logic [7:0]          out_7_0,
    output logic [7:0]          out_15_8,
    output logic                period_start
);

    logic [PWM_BITS-1:0] cnt;
    logic                wrap;
    logic [PWM_BITS-1:0] duty_shadow;
    logic                pwm;
    logic [EN_WIDTH-1:0] en_out;
    logic [EN_WIDTH-1:0] en_pwm;
    logic [EN_WIDTH-1:0] out_next;
    logic [EN_WIDTH-1:0] out_q;

    pwm_timebase #(
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .wrap (wrap)
    );

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign pwm    = pwm_level(cnt, duty_shadow);

    always_comb begin
        out_next = en_out & (~en_pwm | {EN_WIDTH{pwm}});
    end

    // Shadow load, period marker and output register all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow  <= '0;
            period_start <= 1'b0;
            out_q        <= '0;
        end else begin
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
            period_start <= wrap;
            out_q        <= out_next;
        end
    end

    assign out_7_0  = out_q[7:0];
    assign out_15_8 = out_q[15:8];

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench for pwm_peripheral: default PRESCALE instance plus a PRESCALE=1 instance.
module tb_pwm_peripheral;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] en_o;
    logic [15:0] en_p;
    logic [7:0]  duty;
    logic [7:0]  o_lo, o_hi, p_lo, p_hi;
    logic        ps, ps1;
    logic [15:0] out;
    logic [15:0] out_p1;

    assign out    = {o_hi, o_lo};
    assign out_p1 = {p_hi, p_lo};

    always #5 clk = ~clk;

    pwm_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_o[7:0]),
        .en_reg_out_15_8 (en_o[15:8]),
        .en_reg_pwm_7_0  (en_p[7:0]),
        .en_reg_pwm_15_8 (en_p[15:8]),
        .pwm_duty_cycle  (duty),
        .out_7_0         (o_lo),
        .out_15_8        (o_hi),
        .period_start    (ps)
    );

    pwm_peripheral #(.PRESCALE(1)) dut_p1 (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (en_o[7:0]),
        .en_reg_out_15_8 (en_o[15:8]),
        .en_reg_pwm_7_0  (en_p[7:0]),
        .en_reg_pwm_15_8 (en_p[15:8]),
        .pwm_duty_cycle  (duty),
        .out_7_0         (p_lo),
        .out_15_8        (p_hi),
        .period_start    (ps1)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    string tag_q[$];
    int    exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input int obs);
        if (exp_q.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic wait_ps(input bit sel);
        bit found = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (sel ? ps1 : ps) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check("tmo_ps", 0, 1);
    endtask

    task automatic count_to_ps(input bit sel, output int n);
        n = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            n++;
            if (sel ? ps1 : ps) break;
        end
    endtask

    task automatic measure(input int b, input int len, output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (out[b] === 1'b1) hi++;
            if (out[b] === 1'b0) lo++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, lo, hi_a, hi_b;
        rst  = 1'b1;
        en_o = '0;
        en_p = '0;
        duty = 8'h00;
        repeat (3) @(negedge clk);
        sb_push("rst_out", 0);    sb_pop(int'(out));
        sb_push("rst_out_p1", 0); sb_pop(int'(out_p1));
        sb_push("rst_ps", 0);     sb_pop(int'(ps));
        rst = 1'b0;

        en_o = 16'hFFFF;
        sb_push("en_static_on", 16'hFFFF);
        @(negedge clk);
        sb_pop(int'(out));
        en_o = 16'h0000;
        sb_push("en_off", 0);
        @(negedge clk);
        sb_pop(int'(out));

        sb_push("period_dflt", 3328);
        wait_ps(1'b0);
        count_to_ps(1'b0, n);
        sb_pop(n);
        sb_push("period_p1", 256);
        wait_ps(1'b1);
        count_to_ps(1'b1, n);
        sb_pop(n);

        en_o = 16'h0001;
        en_p = 16'h0001;
        duty = 8'h80;
        wait_ps(1'b0);
        sb_push("duty80_hi", 1664);
        sb_push("duty80_lo", 1664);
        measure(0, 3328, hi, lo);
        sb_pop(hi);
        sb_pop(lo);

        en_o = 16'h8000;
        en_p = 16'h8000;
        duty = 8'hFF;
        wait_ps(1'b0);
        sb_push("dutyff_hi", 9984);
        sb_push("dutyff_lo", 0);
        measure(15, 9984, hi, lo);
        sb_pop(hi);
        sb_pop(lo);
        duty = 8'h00;
        wait_ps(1'b0);
        sb_push("duty00_hi", 0);
        sb_push("duty00_lo", 9984);
        measure(15, 9984, hi, lo);
        sb_pop(hi);
        sb_pop(lo);

        en_o = 16'h0001;
        en_p = 16'h0001;
        duty = 8'h40;
        wait_ps(1'b0);
        sb_push("midchg_cur", 832);
        sb_push("midchg_next", 2496);
        hi_a = 0;
        hi_b = 0;
        for (int i = 0; i < 6656; i++) begin
            @(negedge clk);
            if (out[0] === 1'b1) begin
                if (i < 3328) hi_a++;
                else          hi_b++;
            end
            if (i == 207) duty = 8'hC0;
        end
        sb_pop(hi_a);
        sb_pop(hi_b);

        duty = 8'hFF;
        wait_ps(1'b0);
        repeat (1040) @(negedge clk);
        sb_push("pre_rst_hi", 1);
        sb_pop(int'(out[0]));
        #2;
        rst = 1'b1;
        #1;
        sb_push("rst_async_out", 0); sb_pop(int'(out));
        sb_push("rst_async_ps", 0);  sb_pop(int'(ps));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_push("rel_first_ps", 3328);
        sb_push("rel_no_pulse", 0);
        n  = 0;
        hi = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            n++;
            if (out[0] !== 1'b0) hi++;
            if (ps) break;
        end
        sb_pop(n);
        sb_pop(hi);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
